// File: rtl/y86_fetch.sv
// y86_fetch: fetch stage of the sequential Y86-64 processor.
//
// Holds a byte-addressed instruction memory and decodes the instruction at PC
// purely combinationally. The only clocked path is the byte write port used to
// load the program.
//
// Ports:
//   clk         write clock
//   rst_n       asynchronous active-low reset, clears the whole memory to 0x00
//   PC          fetch address
//   imem_we     byte write enable
//   imem_waddr  write byte address (out-of-range writes are dropped)
//   imem_wdata  write byte
//   icode/ifun  high/low nibble of byte PC
//   rA/rB       register specifiers, 0xF when there is no register byte
//   valC        little-endian constant word, 0 when absent
//   valP        PC + instruction length (modulo 2^64)
//   stat        1=AOK, 2=HLT, 3=ADR, 4=INS
module y86_fetch #(
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] PC,
    input  logic        imem_we,
    input  logic [63:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [2:0]  stat
);

    localparam int unsigned AW        = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [63:0] MEM_LIMIT = 64'(IMEM_BYTES);
    localparam int unsigned MAX_LEN   = 10;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    logic [7:0]  mem [IMEM_BYTES];
    logic [7:0]  ibyte [MAX_LEN];
    logic [63:0] rd_addr [MAX_LEN];
    logic        pc_in;

    logic        valid;
    logic        has_reg;
    logic        valc_at1;
    logic        valc_at2;
    logic [3:0]  len;
    logic [63:0] last_addr;
    logic        adr_err;

    // ------------------------------------------------------------------
    // Instruction memory: async clear, synchronous in-range byte writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(IMEM_BYTES); i++) begin
                mem[i] <= 8'h00;
            end
        end else if (imem_we && (imem_waddr < MEM_LIMIT)) begin
            mem[imem_waddr[AW-1:0]] <= imem_wdata;
        end
    end

    assign pc_in = PC < MEM_LIMIT;

    // Fetch window. With PC in range PC+k cannot wrap, so a plain compare
    // against the limit is exact; with PC out of range every byte reads 0.
    always_comb begin
        for (int k = 0; k < int'(MAX_LEN); k++) begin
            rd_addr[k] = PC + 64'(k);
            ibyte[k]   = 8'h00;
            if (pc_in && (rd_addr[k] < MEM_LIMIT)) begin
                ibyte[k] = mem[rd_addr[k][AW-1:0]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        icode    = ibyte[0][7:4];
        ifun     = ibyte[0][3:0];
        valid    = 1'b1;
        has_reg  = 1'b0;
        valc_at1 = 1'b0;
        valc_at2 = 1'b0;
        len      = 4'd1;

        case (icode)
            4'h0, 4'h1, 4'h9: begin
                valid = (ifun == 4'h0);
            end
            4'h2: begin
                valid   = (ifun <= 4'h6);
                has_reg = 1'b1;
                len     = 4'd2;
            end
            4'h3, 4'h4, 4'h5: begin
                valid    = (ifun == 4'h0);
                has_reg  = 1'b1;
                valc_at2 = 1'b1;
                len      = 4'd10;
            end
            4'h6: begin
                valid   = (ifun <= 4'h3);
                has_reg = 1'b1;
                len     = 4'd2;
            end
            4'h7: begin
                valid    = (ifun <= 4'h6);
                valc_at1 = 1'b1;
                len      = 4'd9;
            end
            4'h8: begin
                valid    = (ifun == 4'h0);
                valc_at1 = 1'b1;
                len      = 4'd9;
            end
            4'hA, 4'hB: begin
                valid   = (ifun == 4'h0);
                has_reg = 1'b1;
                len     = 4'd2;
            end
            default: begin
                valid = 1'b0;
            end
        endcase

        // An invalid instruction collapses to a 1-byte slot with no fields.
        if (!valid) begin
            has_reg  = 1'b0;
            valc_at1 = 1'b0;
            valc_at2 = 1'b0;
            len      = 4'd1;
        end

        rA   = has_reg ? ibyte[1][7:4] : 4'hF;
        rB   = has_reg ? ibyte[1][3:0] : 4'hF;
        valC = 64'd0;
        if (valc_at2) begin
            valC = {ibyte[9], ibyte[8], ibyte[7], ibyte[6],
                    ibyte[5], ibyte[4], ibyte[3], ibyte[2]};
        end else if (valc_at1) begin
            valC = {ibyte[8], ibyte[7], ibyte[6], ibyte[5],
                    ibyte[4], ibyte[3], ibyte[2], ibyte[1]};
        end

        valP = PC + 64'(len);

        // Only evaluated when PC is in range, where PC+len-1 cannot wrap.
        last_addr = PC + 64'(len) - 64'd1;
        adr_err   = !pc_in || (last_addr >= MEM_LIMIT);

        if (adr_err) begin
            stat = STAT_ADR;
        end else if (!valid) begin
            stat = STAT_INS;
        end else if (icode == 4'h0) begin
            stat = STAT_HLT;
        end else begin
            stat = STAT_AOK;
        end
    end

endmodule

// File: tb/tb_y86_fetch.sv
module tb_y86_fetch;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [2:0]  stat;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc = 64'd0;
    logic        imem_we = 1'b0;
    logic [63:0] imem_waddr = 64'd0;
    logic [7:0]  imem_wdata = 8'h00;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [2:0]  stat;

    fetch_t exp_q[$];
    logic   chk_req = 1'b0;
    string  chk_name = "";
    int     n_checks = 0;
    int     n_fail = 0;

    y86_fetch #(.IMEM_BYTES(1024)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PC        (pc),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .icode     (icode),
        .ifun      (ifun),
        .rA        (ra),
        .rB        (rb),
        .valC      (valc),
        .valP      (valp),
        .stat      (stat)
    );

    always #5 clk = ~clk;

    // Monitor: samples on the falling edge whenever a check is presented.
    always @(negedge clk) begin
        if (chk_req) begin
            fetch_t act;
            fetch_t exp;
            act = '{icode: icode, ifun: ifun, ra: ra, rb: rb,
                    valc: valc, valp: valp, stat: stat};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: output presented with no expected entry", chk_name);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL %s: got icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h stat=%0d, expected icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h stat=%0d",
                             chk_name, act.icode, act.ifun, act.ra, act.rb, act.valc,
                             act.valp, act.stat, exp.icode, exp.ifun, exp.ra, exp.rb,
                             exp.valc, exp.valp, exp.stat);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] addr, input fetch_t exp);
        @(posedge clk);
        #1;
        pc       = addr;
        chk_name = name;
        exp_q.push_back(exp);
        chk_req  = 1'b1;
        @(posedge clk);
        #1;
        chk_req  = 1'b0;
    endtask

    task automatic wr(input logic [63:0] addr, input logic [7:0] data);
        @(posedge clk);
        #1;
        imem_we    = 1'b1;
        imem_waddr = addr;
        imem_wdata = data;
        @(posedge clk);
        #1;
        imem_we    = 1'b0;
    endtask

    task automatic wr_seq(input logic [63:0] base, input logic [7:0] bytes[$]);
        for (int i = 0; i < bytes.size(); i++) begin
            wr(base + 64'(i), bytes[i]);
        end
    endtask

    function automatic fetch_t halt_at(input logic [63:0] addr);
        return '{icode: 4'h0, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'd0,
                 valp: addr + 64'd1, stat: 3'd2};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        check("reset_pc0", 64'd0, halt_at(64'd0));
        rst_n = 1'b1;
        check("after_reset_pc0", 64'd0, halt_at(64'd0));

        wr_seq(64'd0, '{8'h30, 8'hF0, 8'h23, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        check("irmovq", 64'd0, '{4'h3, 4'h0, 4'hF, 4'h0, 64'h123, 64'd10, 3'd1});

        wr_seq(64'd10, '{8'h70, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        check("jmp", 64'd10, '{4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'd19, 3'd1});
        wr_seq(64'd19, '{8'h61, 8'h23});
        check("subq", 64'd19, '{4'h6, 4'h1, 4'h2, 4'h3, 64'd0, 64'd21, 3'd1});

        wr(64'd30, 8'hC0);
        check("bad_icode", 64'd30, '{4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd31, 3'd4});
        wr(64'd31, 8'h27);
        check("bad_ifun_cmov", 64'd31, '{4'h2, 4'h7, 4'hF, 4'hF, 64'd0, 64'd32, 3'd4});
        wr(64'd32, 8'h90);
        check("ret", 64'd32, '{4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd33, 3'd1});
        wr(64'd33, 8'h11);
        check("bad_ifun_nop", 64'd33, '{4'h1, 4'h1, 4'hF, 4'hF, 64'd0, 64'd34, 3'd4});

        wr_seq(64'd50, '{8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00});
        check("call", 64'd50, '{4'h8, 4'h0, 4'hF, 4'hF, 64'hDEADBEEF, 64'd59, 3'd1});
        wr_seq(64'd60, '{8'hA0, 8'h3F, 8'h26, 8'h12});
        check("pushq", 64'd60, '{4'hA, 4'h0, 4'h3, 4'hF, 64'd0, 64'd62, 3'd1});
        check("cmovg", 64'd62, '{4'h2, 4'h6, 4'h1, 4'h2, 64'd0, 64'd64, 3'd1});

        wr_seq(64'd1020, '{8'h30, 8'hF0});
        check("tail_out_of_range", 64'd1020, '{4'h3, 4'h0, 4'hF, 4'h0, 64'd0, 64'd1030, 3'd3});
        wr(64'd1023, 8'h10);
        check("nop_last_byte", 64'd1023, '{4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1024, 3'd1});
        check("pc_out_of_range", 64'd2000, '{4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd2001, 3'd3});
        check("pc_max_wraps", 64'hFFFF_FFFF_FFFF_FFFF,
              '{4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd3});
        wr(64'd2000, 8'h10);
        check("oor_write_no_alias", 64'd976, halt_at(64'd976));
        check("oor_write_pc0_intact", 64'd0, '{4'h3, 4'h0, 4'hF, 4'h0, 64'h123, 64'd10, 3'd1});

        // Reset mid-load, asserted away from any clock edge.
        wr_seq(64'd100, '{8'h30, 8'hF4});
        #2;
        rst_n = 1'b0;
        check("rst_pc0", 64'd0, halt_at(64'd0));
        check("rst_pc19", 64'd19, halt_at(64'd19));
        check("rst_pc100", 64'd100, halt_at(64'd100));
        wr(64'd5, 8'h10);
        check("rst_write_blocked", 64'd5, halt_at(64'd5));
        rst_n = 1'b1;
        check("post_rst_pc10", 64'd10, halt_at(64'd10));
        check("post_rst_pc1023", 64'd1023, halt_at(64'd1023));

        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
